// File: rtl/inst_pkg.sv
// Shared instruction-format definitions used by the field encoder/loader and the decoder.
// Holds format/state enums, field widths and the common opcode/funct values.
package inst_pkg;

  localparam int INST_W   = 32;
  localparam int OPCODE_W = 6;
  localparam int REG_W    = 5;
  localparam int SHAMT_W  = 5;
  localparam int FUNCT_W  = 6;
  localparam int IMM_W    = 16;
  localparam int JUMP_W   = 26;

  typedef enum logic [1:0] {
    FMT_R   = 2'd0,
    FMT_I   = 2'd1,
    FMT_J   = 2'd2,
    FMT_BAD = 2'd3
  } fmt_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } load_state_t;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2b;

  localparam logic [FUNCT_W-1:0] FN_SLL = 6'h00;
  localparam logic [FUNCT_W-1:0] FN_JR  = 6'h08;
  localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'h25;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'h2a;

endpackage

// File: rtl/inst_encode.sv
// Combinational packer: turns decoded R/I/J fields back into a 32-bit instruction word.
// Fields not belonging to the selected format are ignored; format 3 raises illegal.
module inst_encode
  import inst_pkg::*;
(
  input  fmt_t                fmt,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [REG_W-1:0]    rs,
  input  logic [REG_W-1:0]    rt,
  input  logic [REG_W-1:0]    rd,
  input  logic [SHAMT_W-1:0]  shift,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic [IMM_W-1:0]    imm,
  input  logic [JUMP_W-1:0]   jump,
  output logic [INST_W-1:0]   word,
  output logic                illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (fmt)
      FMT_R:   word = {opcode, rs, rt, rd, shift, funct};
      FMT_I:   word = {opcode, rs, rt, imm};
      FMT_J:   word = {opcode, jump};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/inst_encode_loader.sv
// Loads a stream of decoded instruction fields into instruction memory from BASE_ADDR.
// Each accepted legal entry becomes one registered memory write on the following cycle.
module inst_encode_loader
  import inst_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_fmt,
  input  logic [OPCODE_W-1:0] in_opcode,
  input  logic [REG_W-1:0]    in_rs,
  input  logic [REG_W-1:0]    in_rt,
  input  logic [REG_W-1:0]    in_rd,
  input  logic [SHAMT_W-1:0]  in_shift,
  input  logic [FUNCT_W-1:0]  in_funct,
  input  logic [IMM_W-1:0]    in_imm,
  input  logic [JUMP_W-1:0]   in_jump,
  input  logic                in_last,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [INST_W-1:0]   mem_wdata,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [ADDR_W:0]     count
);

  localparam logic [ADDR_W-1:0] BASE_PTR = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] PTR_MAX  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

  load_state_t         state, state_nxt;
  logic [ADDR_W-1:0]   ptr;
  logic [INST_W-1:0]   word;
  logic                illegal;
  logic                accept;

  inst_encode u_encode (
    .fmt     (fmt_t'(in_fmt)),
    .opcode  (in_opcode),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .shift   (in_shift),
    .funct   (in_funct),
    .imm     (in_imm),
    .jump    (in_jump),
    .word    (word),
    .illegal (illegal)
  );

  assign in_ready = (state == ST_LOAD);
  assign accept   = in_valid && in_ready;
  assign busy     = (state == ST_LOAD);
  assign done     = (state == ST_DONE);
  assign error    = (state == ST_ERR);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // A legal word landing on the last address without in_last overflows capacity.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD: begin
        if (accept) begin
          if (illegal)             state_nxt = ST_ERR;
          else if (in_last)        state_nxt = ST_DONE;
          else if (ptr == PTR_MAX) state_nxt = ST_ERR;
        end
      end
      default: if (start) state_nxt = ST_LOAD;
    endcase
  end

  // The final write is already registered, so it completes even once the state has left LOAD.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ptr       <= BASE_PTR;
      count     <= '0;
    end else begin
      mem_we <= 1'b0;
      if (state != ST_LOAD && start) begin
        ptr   <= BASE_PTR;
        count <= '0;
      end else if (accept && !illegal) begin
        mem_we    <= 1'b1;
        mem_addr  <= ptr;
        mem_wdata <= word;
        ptr       <= ptr + PTR_ONE;
        count     <= count + CNT_ONE;
      end
    end
  end

endmodule
